// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debouncer tick, centisecond enable, run/pause/lap/clear FSM.
// Optional STOPWATCH_AUTOSTOP_EN adds max_reached and pauses at counter maximum.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int CS_DIV  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    input  logic       btn_clr_n,
`ifdef STOPWATCH_AUTOSTOP_EN
    input  logic       max_reached,
`endif
    output logic       db_clk_en,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_sel,
    output logic [1:0] state,
    output logic       running
);

    localparam int PRE_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int CS_W    = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
    localparam logic [CS_W-1:0]  CS_MAX  = CS_W'(CS_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PRE_W-1:0]  r_pre;
    logic [CS_W-1:0]   r_div;
    logic [2:0]        r_btn, r_hist, r_arm;   // bit 0 start, 1 lap, 2 clr
    logic              r_cnt_clr, r_lap_load;
    logic [2:0]        w_btn, w_press;
    logic              w_tick, w_run, w_max, w_stop, w_div_adv, w_div_clr;
    logic              w_cnt_clr_nxt, w_lap_load_nxt;

`ifdef STOPWATCH_AUTOSTOP_EN
    assign w_max = max_reached;
`else
    assign w_max = 1'b0;
`endif

    assign w_btn     = {btn_clr_n, btn_lap_n, btn_start_n};
    // A button only counts once it has been seen released since reset,
    // so one held through reset release never looks like a falling edge.
    assign w_press   = r_arm & r_hist & ~r_btn;
    assign w_tick    = (r_pre == PRE_MAX);
    assign w_run     = r_state[0];
    assign w_stop    = w_run & w_max;
    assign w_div_adv = w_run & w_tick & ~w_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn  <= 3'b111;
            r_hist <= 3'b111;
            r_arm  <= 3'b000;
        end else begin
            r_btn  <= w_btn;
            r_hist <= r_btn;
            r_arm  <= r_arm | w_btn;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_clr_nxt  = 1'b0;
        w_lap_load_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[2])      w_cnt_clr_nxt = 1'b1;
                else if (w_press[0]) w_state_nxt   = S_RUN;
            end
            S_RUN: begin
                if (w_press[0]) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_press[1]) begin
                    w_state_nxt    = S_LAP;
                    w_lap_load_nxt = 1'b1;
                end
            end
            S_LAP: begin
                if (w_press[0])      w_state_nxt    = S_PAUSE;
                else if (w_press[1]) w_lap_load_nxt = 1'b1;
            end
            S_PAUSE: begin
                if (w_press[2]) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_clr_nxt = 1'b1;
                end else if (w_press[0] && !w_max) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_stop) begin
            w_state_nxt    = S_PAUSE;
            w_lap_load_nxt = 1'b0;
        end
    end

    // Fresh start or clear restarts the sub-centisecond phase; pause keeps it.
    assign w_div_clr = w_cnt_clr_nxt | ((r_state == S_IDLE) && (w_state_nxt == S_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt_clr  <= 1'b0;
            r_lap_load <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt_clr  <= w_cnt_clr_nxt;
            r_lap_load <= w_lap_load_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_div_clr) begin
            r_div <= '0;
        end else if (w_div_adv) begin
            r_div <= (r_div == CS_MAX) ? '0 : r_div + 1'b1;
        end
    end

    assign db_clk_en = w_tick;
    assign cnt_en    = w_div_adv & (r_div == CS_MAX);
    assign cnt_clr   = r_cnt_clr;
    assign lap_load  = r_lap_load;
    assign disp_sel  = (r_state == S_LAP);
    assign state     = r_state;
    assign running   = w_run;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic
// compared every cycle against a mode/phase reference model.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int CS_DIV  = 3;
    localparam int PRE     = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_AUTOSTOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b111;   // {clr, lap, start}, active-low
    logic       mx = 1'b0;
    logic       db_clk_en, cnt_en, cnt_clr, lap_load, disp_sel, running;
    logic [1:0] state;

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CS_DIV(CS_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start_n(btn[0]),
        .btn_lap_n  (btn[1]),
        .btn_clr_n  (btn[2]),
`ifdef STOPWATCH_AUTOSTOP_EN
        .max_reached(mx),
`endif
        .db_clk_en  (db_clk_en),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .lap_load   (lap_load),
        .disp_sel   (disp_sel),
        .state      (state),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_t;

    int    checks = 0, errors = 0;
    int    n_cnt = 0, n_lap = 0, n_clr = 0;
    mode_t m_mode = M_IDLE;
    int    m_cyc = 0, m_phase = 0;
    bit    m_clr = 0, m_lap = 0;
    bit [2:0] m_hist = 3'b111, m_cur = 3'b111, m_arm = 3'b000;

    function automatic logic [1:0] mode_code(input mode_t m);
        case (m)
            M_RUN:   return 2'b01;
            M_PAUSE: return 2'b10;
            M_LAP:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit e_run();  return (m_mode == M_RUN) || (m_mode == M_LAP); endfunction
    function automatic bit e_tick(); return (m_cyc % PRE) == PRE - 1;                endfunction
    function automatic bit e_stop(); return AUTO && (mx === 1'b1) && e_run();        endfunction
    function automatic bit e_cnt();  return e_run() && e_tick() && (m_phase == CS_DIV - 1) && !e_stop(); endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cyc = 0; m_phase = 0; m_clr = 0; m_lap = 0;
        m_hist = 3'b111; m_cur = 3'b111; m_arm = 3'b000;
    endtask

    task automatic model_edge();
        bit [2:0] p;
        mode_t    nm;
        bit       c, l;
        p  = m_arm & m_hist & ~m_cur;
        nm = m_mode; c = 0; l = 0;
        case (m_mode)
            M_IDLE:  if (p[2]) c = 1; else if (p[0]) nm = M_RUN;
            M_RUN:   if (p[0]) nm = M_PAUSE; else if (p[1]) begin nm = M_LAP; l = 1; end
            M_LAP:   if (p[0]) nm = M_PAUSE; else if (p[1]) l = 1;
            default: if (p[2]) begin nm = M_IDLE; c = 1; end
                     else if (p[0] && !(AUTO && mx === 1'b1)) nm = M_RUN;
        endcase
        if (e_stop()) begin nm = M_PAUSE; l = 0; end
        if (e_run() && e_tick() && !e_stop()) m_phase = (m_phase + 1) % CS_DIV;
        if (c || (m_mode == M_IDLE && nm == M_RUN)) m_phase = 0;
        m_mode = nm; m_clr = c; m_lap = l; m_cyc++;
        m_hist = m_cur; m_cur = btn; m_arm = m_arm | btn;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("db_clk_en", {7'd0, db_clk_en}, {7'd0, e_tick()});
        chk("cnt_en",    {7'd0, cnt_en},    {7'd0, e_cnt()});
        chk("cnt_clr",   {7'd0, cnt_clr},   {7'd0, m_clr});
        chk("lap_load",  {7'd0, lap_load},  {7'd0, m_lap});
        chk("disp_sel",  {7'd0, disp_sel},  {7'd0, m_mode == M_LAP});
        chk("state",     {6'd0, state},     {6'd0, mode_code(m_mode)});
        chk("running",   {7'd0, running},   {7'd0, e_run()});
    endtask

    // Check at negedge, then drive new inputs; model advances after posedge.
    task automatic step(input logic [2:0] b, input logic r = 1'b1, input logic m = 1'b0);
        @(negedge clk);
        check_all();
        if (cnt_en === 1'b1)   n_cnt++;
        if (lap_load === 1'b1) n_lap++;
        if (cnt_clr === 1'b1)  n_clr++;
        btn = b; mx = m;
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
        end else begin
            rst_n = r;
        end
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
    endtask

    task automatic press(input int idx, input int hold = 2);
        logic [2:0] b;
        b = 3'b111; b[idx] = 1'b0;
        repeat (hold) step(b);
        repeat (3) step(3'b111);
    endtask

    initial begin
        logic [2:0] rb;
        int         guard;
        model_reset();
        repeat (3)  step(3'b110, 1'b0);
        repeat (25) step(3'b110);
        chk("held_start_idle", {6'd0, state}, 8'd0);
        repeat (5) step(3'b111);

        // start from IDLE, count over the first 150 RUN cycles
        repeat (2) step(3'b110);
        chk("start_latency", {6'd0, state}, 8'd0);
        n_cnt = 0;
        repeat (150) step(3'b110);
        chk("cnt_en_in_150", 8'(n_cnt), 8'd5);
        chk("run_state", {6'd0, state}, 8'd1);
        repeat (3) step(3'b111);

        n_lap = 0;
        press(1);
        repeat (30) step(3'b111);
        press(1);
        chk("lap_loads", 8'(n_lap), 8'd2);
        chk("lap_state", {6'd0, state}, 8'd3);
        press(0);
        chk("pause_state", {6'd0, state}, 8'd2);
        chk("pause_disp", {7'd0, disp_sel}, 8'd0);
        n_cnt = 0;
        repeat (60) step(3'b111);
        chk("paused_no_cnt", 8'(n_cnt), 8'd0);

        // pause with two of three divider ticks taken, resume keeps the phase
        press(0);
        guard = 0;
        while (!(m_phase == CS_DIV - 1 && m_cyc % PRE == 0) && guard < 200) begin
            step(3'b111); guard++;
        end
        chk("phase_wait", 8'(guard < 200), 8'd1);
        repeat (2) step(3'b110);
        repeat (20) step(3'b111);
        chk("paused_mid", {6'd0, state}, 8'd2);
        repeat (2) step(3'b110);
        n_cnt = 0;
        repeat (PRE) step(3'b111);
        chk("phase_kept", 8'(n_cnt), 8'd1);

        // triple press: RUN -> PAUSE only; PAUSE -> IDLE with one clear
        n_lap = 0; n_clr = 0;
        repeat (2) step(3'b000);
        repeat (3) step(3'b111);
        chk("triple_run", {6'd0, state}, 8'd2);
        repeat (2) step(3'b000);
        repeat (3) step(3'b111);
        chk("triple_pause", {6'd0, state}, 8'd0);
        chk("triple_clr", 8'(n_clr), 8'd1);
        chk("triple_lap", 8'(n_lap), 8'd0);

        rb = 3'b111;
        repeat (2500) begin
            if ($urandom_range(39) == 0) rb[0] = ~rb[0];
            if ($urandom_range(19) == 0) rb[1] = ~rb[1];
            if ($urandom_range(59) == 0) rb[2] = ~rb[2];
            step(rb);
        end
        repeat (3) step(3'b111);

        // reset in the middle of RUN
        guard = 0;
        while (m_mode != M_RUN && guard < 6) begin
            press(0); guard++;
        end
        chk("reach_run", {6'd0, state}, 8'd1);
        repeat (40) step(3'b111);
        step(3'b111, 1'b0);
        repeat (3) step(3'b111, 1'b0);
        n_cnt = 0;
        repeat (100) step(3'b111);
        chk("post_reset_cnt", 8'(n_cnt), 8'd0);
        chk("post_reset_idle", {6'd0, state}, 8'd0);

`ifdef STOPWATCH_AUTOSTOP_EN
        press(0);
        repeat (10) step(3'b111);
        step(3'b111, 1'b1, 1'b1);
        chk("autostop_pause", {6'd0, state}, 8'd2);
        repeat (2) step(3'b110, 1'b1, 1'b1);
        repeat (3) step(3'b111, 1'b1, 1'b1);
        chk("autostop_start_ignored", {6'd0, state}, 8'd2);
        press(2);
        chk("autostop_clr", {6'd0, state}, 8'd0);
`endif

        step(3'b111);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
